// File: rtl/dkong_loader_pkg.sv
// Shared types and constants for the Donkey Kong ROM download loader.
// Index numbers follow the hps_io download menu layout.
package dkong_loader_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY,
        ERROR
    } load_state_t;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    localparam int unsigned DEF_MAIN_END  = 'h8000;
    localparam int unsigned DEF_SND_BASE  = 'hE000;
    localparam int unsigned DEF_WAV_BASE  = 'hFF00;
    localparam int unsigned DEF_WAV_AW    = 16;
    localparam int unsigned DEF_MIN_BYTES = 'h8000;

endpackage

// File: rtl/dkong_rom_loader.sv
// Routes ioctl download bytes into the DK ROM DPRAMs, latches game/DIP bytes
// and holds the core in reset until a complete ROM set has been loaded.
module dkong_rom_loader
    import dkong_loader_pkg::*;
#(
    parameter int unsigned MAIN_END  = DEF_MAIN_END,
    parameter int unsigned SND_BASE  = DEF_SND_BASE,
    parameter int unsigned WAV_BASE  = DEF_WAV_BASE,
    parameter int unsigned WAV_AW    = DEF_WAV_AW,
    parameter int unsigned MIN_BYTES = DEF_MIN_BYTES
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              main_we,
    output logic [14:0]       main_addr,
    output logic              snd_we,
    output logic [11:0]       snd_addr,
    output logic              wav_we,
    output logic [WAV_AW-1:0] wav_addr,
    output logic [7:0]        rom_data,
    output logic [7:0]        game_mod,
    output logic [7:0]        dip_sw,
    output logic [24:0]       byte_count,
    output logic              rom_valid,
    output logic              load_error,
    output logic              core_hold
);

    localparam int unsigned SND_END = SND_BASE + 32'd4096;
    localparam int unsigned WAV_END = WAV_BASE + (32'd1 << WAV_AW);
    localparam logic [24:0] SND_B   = SND_BASE[24:0];
    localparam logic [24:0] WAV_B   = WAV_BASE[24:0];

    load_state_t state, state_n;

    logic        dl_q;
    logic [7:0]  idx_q;
    logic        rise, fall;
    logic        rom_wr;
    logic [31:0] a32;
    logic        in_main, in_snd, in_wav;
    logic [25:0] a_p1;
    logic [24:0] a_len;
    logic [24:0] bc_next;
    logic [24:0] snd_off, wav_off;

    assign rise = ioctl_download & ~dl_q;
    assign fall = ~ioctl_download & dl_q;

    assign rom_wr = ioctl_wr && state == LOADING
                 && ioctl_index == IDX_ROM && idx_q == IDX_ROM;

    assign a32     = {7'd0, ioctl_addr};
    assign in_main = a32 < MAIN_END;
    assign in_snd  = a32 >= SND_BASE && a32 < SND_END;
    assign in_wav  = a32 >= WAV_BASE && a32 < WAV_END;
    assign snd_off = ioctl_addr - SND_B;
    assign wav_off = ioctl_addr - WAV_B;

    // Length is addr+1, pinned at all-ones so the top address cannot wrap to 0.
    assign a_p1    = {1'b0, ioctl_addr} + 26'd1;
    assign a_len   = a_p1[25] ? '1 : a_p1[24:0];
    assign bc_next = (rom_wr && a_len > byte_count) ? a_len : byte_count;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= EMPTY;
        else       state <= state_n;
    end

    // The closing write is folded in through bc_next before the length test.
    always_comb begin
        state_n = state;
        if (rise && ioctl_index == IDX_ROM)
            state_n = LOADING;
        else if (fall && state == LOADING && idx_q == IDX_ROM)
            state_n = ({7'd0, bc_next} >= MIN_BYTES) ? READY : ERROR;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q       <= ioctl_download;
            idx_q      <= 8'd0;
            byte_count <= '0;
            main_we    <= 1'b0;
            snd_we     <= 1'b0;
            wav_we     <= 1'b0;
            main_addr  <= '0;
            snd_addr   <= '0;
            wav_addr   <= '0;
            rom_data   <= 8'd0;
            game_mod   <= 8'd0;
            dip_sw     <= 8'd0;
        end else begin
            dl_q <= ioctl_download;
            if (rise) idx_q <= ioctl_index;
            if (rise && ioctl_index == IDX_ROM) byte_count <= '0;
            else                                byte_count <= bc_next;
            main_we <= rom_wr && in_main;
            snd_we  <= rom_wr && !in_main && in_snd;
            wav_we  <= rom_wr && !in_main && !in_snd && in_wav;
            if (rom_wr) begin
                main_addr <= ioctl_addr[14:0];
                snd_addr  <= snd_off[11:0];
                wav_addr  <= wav_off[WAV_AW-1:0];
                rom_data  <= ioctl_dout;
            end
            if (ioctl_wr && ioctl_index == IDX_MOD)
                game_mod <= ioctl_dout;
            if (ioctl_wr && ioctl_index == IDX_DIP && ioctl_addr == 25'd0)
                dip_sw <= ioctl_dout;
        end
    end

    assign rom_valid  = state == READY;
    assign load_error = state == ERROR;
    assign core_hold  = ~rom_valid;

endmodule
